// File: rtl/pc_seq.sv
// Program-counter sequencer with a return-address stack for CALL/RET.
// Stack overflow and underflow raise a sticky error flag that only rst clears.
module pc_seq #(
    parameter int unsigned    AW      = 18,
    parameter int unsigned    DEPTH   = 8,
    parameter logic [AW-1:0]  RST_VEC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               op,
    input  logic [AW-1:0]            target,
    input  logic [AW-1:0]            offset,
    output logic [AW-1:0]            pc_out,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     ras_empty,
    output logic                     ras_full,
    output logic                     err
);

    localparam int unsigned AIW = $clog2(DEPTH);
    localparam int unsigned SPW = AIW + 1;

    localparam logic [2:0] OP_INC   = 3'b000;
    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_BRREL = 3'b010;
    localparam logic [2:0] OP_CALL  = 3'b011;
    localparam logic [2:0] OP_RET   = 3'b100;

    logic [AW-1:0]  pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic           ras_empty_q, ras_full_q;
    logic [AW-1:0]  stack_q [DEPTH];
    logic [AW-1:0]  stack_d [DEPTH];

    logic [AW-1:0]  pc_inc;
    logic           full_now;
    logic           empty_now;
    logic [AIW-1:0] push_idx;
    logic [AIW-1:0] pop_idx;

    // Next-state decode for PC, stack pointer, stack contents and error flag.
    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        err_d     = err_q;
        stack_d   = stack_q;
        pc_inc    = pc_q + AW'(1);
        full_now  = (sp_q == SPW'(DEPTH));
        empty_now = (sp_q == SPW'(0));
        push_idx  = sp_q[AIW-1:0];
        pop_idx   = AIW'(sp_q - SPW'(1));

        if (en) begin
            case (op)
                OP_INC:   pc_d = pc_inc;
                OP_JMP:   pc_d = target;
                OP_BRREL: pc_d = pc_q + offset;
                OP_CALL: begin
                    pc_d = target;
                    if (full_now) begin
                        err_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = pc_inc;
                        sp_d              = sp_q + SPW'(1);
                    end
                end
                OP_RET: begin
                    if (empty_now) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d = stack_q[pop_idx];
                        sp_d = sp_q - SPW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state; reset discards any pending return addresses via sp.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RST_VEC;
            sp_q        <= '0;
            err_q       <= 1'b0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            err_q       <= err_d;
            ras_empty_q <= (sp_d == SPW'(0));
            ras_full_q  <= (sp_d == SPW'(DEPTH));
        end
    end

    // Stack storage is not reset; entries are only read below sp.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stack_q <= stack_d;
        end
    end

    assign pc_out    = pc_q;
    assign sp        = sp_q;
    assign ras_empty = ras_empty_q;
    assign ras_full  = ras_full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed vector table, hand sequences for stack corners,
// and random traffic checked against a queue-based reference model.
module tb_pc_seq;

    localparam int unsigned AW    = 18;
    localparam int unsigned DEPTH = 8;
    localparam logic [AW-1:0] RST_VEC = '0;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [2:0]             op;
    logic [AW-1:0]          target;
    logic [AW-1:0]          offset;
    logic [AW-1:0]          pc_out;
    logic [$clog2(DEPTH):0] sp;
    logic                   ras_empty;
    logic                   ras_full;
    logic                   err;

    pc_seq #(.AW(AW), .DEPTH(DEPTH), .RST_VEC(RST_VEC)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .pc_out    (pc_out),
        .sp        (sp),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: PC value, return stack as a queue, sticky error bit.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_err;

    typedef struct {
        logic          rst;
        logic          en;
        logic [2:0]    op;
        logic [AW-1:0] target;
        logic [AW-1:0] offset;
        logic [AW-1:0] exp_pc;
        int            exp_sp;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [2:0] o,
                              input logic [AW-1:0] t, input logic [AW-1:0] f);
        logic [AW-1:0] ret_addr;
        if (r) begin
            m_pc  = RST_VEC;
            m_stk.delete();
            m_err = 1'b0;
        end else if (e) begin
            ret_addr = m_pc + AW'(1);
            case (o)
                3'd0: m_pc = ret_addr;
                3'd1: m_pc = t;
                3'd2: m_pc = m_pc + f;
                3'd3: begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(ret_addr);
                    else m_err = 1'b1;
                    m_pc = t;
                end
                3'd4: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_pc  = ret_addr;
                        m_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle, advance the model, then sample just after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] o,
                        input logic [AW-1:0] t, input logic [AW-1:0] f);
        rst = r; en = e; op = o; target = t; offset = f;
        @(posedge clk);
        model_step(r, e, o, t, f);
        #1;
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".pc"},    longint'(pc_out),    longint'(m_pc));
        cmp({tag, ".sp"},    longint'(sp),        longint'(m_stk.size()));
        cmp({tag, ".empty"}, longint'(ras_empty), longint'(m_stk.size() == 0));
        cmp({tag, ".full"},  longint'(ras_full),  longint'(m_stk.size() == DEPTH));
        cmp({tag, ".err"},   longint'(err),       longint'(m_err));
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] o,
                                input logic [AW-1:0] t, input logic [AW-1:0] f,
                                input logic [AW-1:0] pc, input int s, input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.op = o; v.target = t; v.offset = f;
        v.exp_pc = pc; v.exp_sp = s; v.exp_err = er;
        return v;
    endfunction

    initial begin
        logic [AW-1:0] pushed [DEPTH];
        logic [2:0]    rop;
        logic          ren, rrst;
        logic [AW-1:0] rt, rf;

        m_pc = RST_VEC; m_err = 1'b0;
        rst = 1'b1; en = 1'b0; op = 3'd0; target = '0; offset = '0;

        // rst, en, op, target, offset, exp pc, exp sp, exp err
        vecs.push_back(mk(1, 0, 3'd0, 18'h0,     18'h0,     18'h0,     0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 18'h0,     18'h0,     18'h1,     0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 18'h0,     18'h0,     18'h2,     0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 18'h0,     18'h0,     18'h3,     0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 18'h0,     18'h0,     18'h4,     0, 0));
        vecs.push_back(mk(0, 0, 3'd0, 18'h0,     18'h0,     18'h4,     0, 0));
        vecs.push_back(mk(0, 0, 3'd3, 18'h3000,  18'h0,     18'h4,     0, 0));
        vecs.push_back(mk(0, 0, 3'd4, 18'h0,     18'h0,     18'h4,     0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 18'h3FFFF, 18'h0,     18'h3FFFF, 0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 18'h0,     18'h0,     18'h0,     0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 18'h10,    18'h0,     18'h10,    0, 0));
        vecs.push_back(mk(0, 1, 3'd2, 18'h0,     18'h3FFF0, 18'h0,     0, 0));
        vecs.push_back(mk(0, 1, 3'd2, 18'h0,     18'h5,     18'h5,     0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 18'h2AAAA, 18'h15555, 18'h6,     0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 18'h100,   18'h0,     18'h100,   0, 0));
        vecs.push_back(mk(0, 1, 3'd3, 18'h200,   18'h123,   18'h200,   1, 0));
        vecs.push_back(mk(0, 1, 3'd4, 18'h3333,  18'h77,    18'h101,   0, 0));
        vecs.push_back(mk(0, 1, 3'd5, 18'h3333,  18'h77,    18'h101,   0, 0));
        vecs.push_back(mk(0, 1, 3'd7, 18'h1234,  18'h5,     18'h101,   0, 0));
        vecs.push_back(mk(1, 1, 3'd1, 18'h999,   18'h0,     18'h0,     0, 0));
        vecs.push_back(mk(0, 1, 3'd4, 18'h0,     18'h0,     18'h1,     0, 1));
        vecs.push_back(mk(0, 1, 3'd0, 18'h0,     18'h0,     18'h2,     0, 1));
        vecs.push_back(mk(0, 1, 3'd6, 18'h0,     18'h0,     18'h2,     0, 1));
        vecs.push_back(mk(1, 0, 3'd0, 18'h0,     18'h0,     18'h0,     0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].target, vecs[i].offset);
            cmp($sformatf("vec%0d.pc", i),    longint'(pc_out),    longint'(vecs[i].exp_pc));
            cmp($sformatf("vec%0d.sp", i),    longint'(sp),        longint'(vecs[i].exp_sp));
            cmp($sformatf("vec%0d.empty", i), longint'(ras_empty), longint'(vecs[i].exp_sp == 0));
            cmp($sformatf("vec%0d.full", i),  longint'(ras_full),  longint'(vecs[i].exp_sp == DEPTH));
            cmp($sformatf("vec%0d.err", i),   longint'(err),       longint'(vecs[i].exp_err));
        end

        // Fill the stack past DEPTH, then unwind in reverse push order.
        step(1, 0, 3'd0, '0, '0);
        step(0, 1, 3'd1, 18'h1000, '0);
        pushed[0] = 18'h1001;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(0, 1, 3'd3, AW'(18'h2000 + i * 16), '0);
            if (i + 1 < DEPTH) pushed[i + 1] = AW'(18'h2001 + i * 16);
            check_model($sformatf("call%0d", i));
        end
        cmp("ovf.sp",   longint'(sp),       longint'(DEPTH));
        cmp("ovf.full", longint'(ras_full), 1);
        cmp("ovf.err",  longint'(err),      1);
        cmp("ovf.pc",   longint'(pc_out),   longint'(18'h2080));
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step(0, 1, 3'd4, 18'h3FFFF, '0);
            cmp($sformatf("ret%0d.pc", i), longint'(pc_out), longint'(pushed[i]));
            check_model($sformatf("ret%0d", i));
        end
        cmp("unwound.empty", longint'(ras_empty), 1);

        // Reset mid-stack with a CALL presented must not push.
        step(1, 0, 3'd0, '0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 3'd3, AW'(18'h500 + i), '0);
        cmp("pre_rst.sp", longint'(sp), 3);
        step(1, 1, 3'd3, 18'h777, '0);
        cmp("rst_call.pc",  longint'(pc_out), longint'(RST_VEC));
        cmp("rst_call.sp",  longint'(sp),     0);
        cmp("rst_call.err", longint'(err),    0);
        step(0, 1, 3'd4, '0, '0);
        cmp("rst_call.ret_pc",  longint'(pc_out), longint'(RST_VEC + AW'(1)));
        cmp("rst_call.ret_err", longint'(err),    1);
        check_model("rst_call");

        // Random traffic biased toward CALL/RET so both stack limits get hit.
        step(1, 0, 3'd0, '0, '0);
        for (int n = 0; n < 3000; n++) begin
            rrst = ($urandom_range(0, 199) == 0);
            ren  = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 9))
                0, 1:    rop = 3'd3;
                2, 3:    rop = 3'd4;
                4:       rop = 3'd0;
                5:       rop = 3'd1;
                6:       rop = 3'd2;
                default: rop = 3'($urandom_range(0, 7));
            endcase
            rt = AW'($urandom);
            rf = AW'($urandom);
            step(rrst, ren, rop, rt, rf);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL provide parameter AW, default 18, program-counter and address width in bits.
REQ-002 SHALL provide parameter DEPTH, default 8, return-address stack entries (power of two, >=2).
REQ-003 SHALL provide parameter RST_VEC, default 0, AW-bit PC value loaded on reset.
REQ-004 SHALL provide port clk  input  1  rising-edge clock.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port en  input  1  advance enable; 0 = stall.
REQ-007 SHALL provide port op  input  3  operation: 000 INC, 001 JMP, 010 BRREL, 011 CALL, 100 RET, 101-111 reserved.
REQ-008 SHALL provide port target  input  AW  absolute destination for JMP/CALL.
REQ-009 SHALL provide port offset  input  AW  two's-complement displacement for BRREL.
REQ-010 SHALL provide port pc_out  output  AW  current PC, registered.
REQ-011 SHALL provide port sp  output  log2(DEPTH)+1  stack occupancy, 0..DEPTH.
REQ-012 SHALL provide port ras_empty  output  1  high when sp==0.
REQ-013 SHALL provide port ras_full  output  1  high when sp==DEPTH.
REQ-014 SHALL provide port err  output  1  sticky stack overflow/underflow flag.

Function
REQ-015 SHALL update all state only on rising clk; every output is a register or a decode of registers, never high-impedance.
REQ-016 SHALL, with en=0 and rst=0, hold pc_out, stack contents, sp and err unchanged regardless of op.
REQ-017 SHALL, on en=1 and INC, load pc_out+1 modulo 2^AW; all-ones wraps to 0.
REQ-018 SHALL, on en=1 and JMP, load target.
REQ-019 SHALL, on en=1 and BRREL, load (pc_out+offset) modulo 2^AW, offset sign-interpreted, carry discarded.
REQ-020 SHALL, on en=1 and CALL with sp<DEPTH, write (pc_out+1) mod 2^AW into entry sp, increment sp, load target.
REQ-021 SHALL, on en=1 and CALL with sp==DEPTH, load target, leave stack and sp unchanged, set err.
REQ-022 SHALL, on en=1 and RET with sp>0, load entry sp-1 and decrement sp.
REQ-023 SHALL, on en=1 and RET with sp==0, load pc_out+1, leave sp at 0, set err.
REQ-024 SHALL, on en=1 and reserved op, hold pc_out, stack, sp and err.
REQ-025 SHALL make each update visible on pc_out/sp/flags the cycle after the triggering edge: one-cycle latency, no combinational input-to-output path.
REQ-026 SHALL keep err set once raised until rst; no other input clears it.
REQ-027 SHALL ignore target for all ops except JMP/CALL and offset for all ops except BRREL.

Reset
REQ-028 SHALL, on any edge with rst=1, load pc_out=RST_VEC, sp=0, err=0, ras_empty=1, ras_full=0, overriding en and op.
REQ-029 SHALL treat stack entry contents as don't-care after reset; no RET can read them before a CALL writes them.
REQ-030 SHALL, when rst asserts mid-sequence (stack partly filled), discard all pending return addresses on that edge.

Verification
REQ-031 SHALL cover: reset, 4 cycles INC with en=1 -> pc_out 0,1,2,3,4; then en=0 for 3 cycles -> pc_out stays 4.
REQ-032 SHALL cover: pc_out=0x3FFFF, INC -> 0x00000; pc_out=0x00010, BRREL offset=0x3FFF0 (-16) -> 0x00000; offset=0x00005 -> 0x00005.
REQ-033 SHALL cover: pc_out=0x100, CALL target=0x200 -> pc_out=0x200, sp=1; RET -> pc_out=0x101, sp=0, ras_empty=1, err=0.
REQ-034 SHALL cover: DEPTH=8, 9 CALLs -> sp=8, ras_full=1, err=1 after 9th; 8 RETs return addresses in reverse push order.
REQ-035 SHALL cover: from reset, RET -> pc_out=RST_VEC+1, sp=0, err=1; then INC -> err stays 1; rst -> err=0.
REQ-036 SHALL cover: sp=3, rst asserted with op=CALL, en=1 -> pc_out=RST_VEC, sp=0, no push.
